// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store controller feeding the MEM/WB register. Accepts the
//   access held in EX/MEM, runs a req/ack handshake with data memory, and
//   stalls the upstream pipeline while the access is outstanding. The raw
//   read word is captured into MEM_ReadData. Load-type extraction is done in WB.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_mem_valid/memread/memwrite/size/addr/wdata   access from EX/MEM
//   dmem_req/we/addr/be/wdata   registered request to data memory
//   dmem_ack, dmem_rdata        completion pulse and read word from memory
//   mem_stall                   freeze IF/ID/EX/EX-MEM this cycle
//   MEM_ReadData                captured read word, to MEM/WB
//   align_err                   1-cycle pulse, misaligned access dropped
//   bus_err                     high in the DONE cycle of a timed-out access
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_valid,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [1:0]  ex_mem_size,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEM_ReadData,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;

    logic        access;
    logic        misaligned;
    logic        launch;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [3:0]  byte_sel;

    assign access      = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);
    assign misaligned  = ((ex_mem_size == 2'b01) & ex_mem_addr[0]) |
                         (ex_mem_size[1] & (ex_mem_addr[1:0] != 2'b00));
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

    // One-hot byte lane selected by the low address bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_sel
            assign byte_sel[gi] = (ex_mem_addr[1:0] == 2'(gi));
        end
    endgenerate

    // Byte enables and lane-replicated store data. Size 11 behaves as word.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = ex_mem_wdata;
        case (ex_mem_size)
            2'b00: begin
                be_next    = byte_sel;
                wdata_next = {4{ex_mem_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ex_mem_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = ex_mem_wdata;
            end
        endcase
    end

    // Next-state and combinational handshake outputs.
    always_comb begin
        state_next = state_reg;
        mem_stall  = 1'b0;
        align_err  = 1'b0;
        launch     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access && !misaligned) begin
                    mem_stall  = 1'b1;
                    launch     = 1'b1;
                    state_next = REQ;
                end else if (access) begin
                    align_err = 1'b1;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Instruction moves into MEM/WB at this edge; never relaunch.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            MEM_ReadData <= '0;
            bus_err      <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        dmem_req   <= 1'b1;
                        // Read and write both set is treated as a store.
                        dmem_we    <= ex_mem_memwrite;
                        dmem_addr  <= {ex_mem_addr[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                        cnt_reg    <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            MEM_ReadData <= dmem_rdata;
                        end
                    end else if (timeout_hit) begin
                        dmem_req     <= 1'b0;
                        MEM_ReadData <= '0;
                        bus_err      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    bus_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_valid, ex_mem_memread, ex_mem_memwrite;
    logic [1:0]  ex_mem_size;
    logic [31:0] ex_mem_addr, ex_mem_wdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] MEM_ReadData;
    logic        align_err, bus_err;

    int checks = 0;
    int errors = 0;
    int stalls;
    int req_cycles;

    mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_valid(ex_mem_valid), .ex_mem_memread(ex_mem_memread),
        .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_size(ex_mem_size),
        .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .MEM_ReadData(MEM_ReadData),
        .align_err(align_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        ex_mem_valid    = v;
        ex_mem_memread  = rd;
        ex_mem_memwrite = wr;
        ex_mem_size     = sz;
        ex_mem_addr     = a;
        ex_mem_wdata    = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #12;
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_rdata", MEM_ReadData, 32'h0);
        chk("rst_stall", {31'b0, mem_stall}, 32'h0);
        nxt();
        rst_n = 1'b1;

        // Word load 0x104, ack in first REQ cycle.
        nxt();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0);
        #1;
        chk("wl_idle_stall", {31'b0, mem_stall}, 32'h1);
        chk("wl_idle_req", {31'b0, dmem_req}, 32'h0);
        nxt();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("wl_req", {31'b0, dmem_req}, 32'h1);
        chk("wl_addr", dmem_addr, 32'h0000_0104);
        chk("wl_be", {28'b0, dmem_be}, 32'hF);
        chk("wl_we", {31'b0, dmem_we}, 32'h0);
        chk("wl_req_stall", {31'b0, mem_stall}, 32'h1);
        nxt();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        chk("wl_done_stall", {31'b0, mem_stall}, 32'h0);
        chk("wl_done_rdata", MEM_ReadData, 32'hDEAD_BEEF);
        chk("wl_done_req", {31'b0, dmem_req}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Byte store 0x203, three wait cycles then ack.
        nxt();
        drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'h0000_00A5);
        #1;
        stalls = mem_stall ? 1 : 0;
        for (int w = 0; w < 4; w++) begin
            nxt();
            dmem_ack = (w == 3);
            #1;
            if (mem_stall) stalls++;
            chk($sformatf("bs_req_w%0d", w), {31'b0, dmem_req}, 32'h1);
            chk($sformatf("bs_addr_w%0d", w), dmem_addr, 32'h0000_0200);
            chk($sformatf("bs_be_w%0d", w), {28'b0, dmem_be}, 32'h8);
            chk($sformatf("bs_wdata_w%0d", w), dmem_wdata, 32'hA5A5_A5A5);
            chk($sformatf("bs_we_w%0d", w), {31'b0, dmem_we}, 32'h1);
        end
        nxt();
        dmem_ack = 1'b0;
        #1;
        chk("bs_done_stall", {31'b0, mem_stall}, 32'h0);
        chk("bs_stall_cycles", stalls, 32'd5);
        chk("bs_rdata_kept", MEM_ReadData, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Misaligned half load 0x11.
        nxt();
        drive(1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0011, 32'h0);
        #1;
        chk("mis_align_err", {31'b0, align_err}, 32'h1);
        chk("mis_stall", {31'b0, mem_stall}, 32'h0);
        nxt();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk("mis_req", {31'b0, dmem_req}, 32'h0);
        chk("mis_align_clr", {31'b0, align_err}, 32'h0);

        // Load with no ack: timeout after 16 REQ cycles.
        nxt();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
        #1;
        req_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            nxt();
            if (dmem_req) req_cycles++;
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        nxt();
        chk("to_done_req", {31'b0, dmem_req}, 32'h0);
        chk("to_bus_err", {31'b0, bus_err}, 32'h1);
        chk("to_rdata", MEM_ReadData, 32'h0);
        chk("to_done_stall", {31'b0, mem_stall}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        nxt();
        chk("to_bus_err_clr", {31'b0, bus_err}, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        nxt();
        dmem_ack = 1'b0;
        #1;
        chk("late_ack_rdata", MEM_ReadData, 32'h0);
        chk("late_ack_req", {31'b0, dmem_req}, 32'h0);
        chk("late_ack_stall", {31'b0, mem_stall}, 32'h0);

        // Back-to-back: word load 0x80 then half store 0x6.
        nxt();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0080, 32'h0);
        #1;
        nxt();
        chk("bb1_req", {31'b0, dmem_req}, 32'h1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234_5678;
        nxt();
        dmem_ack = 1'b0;
        #1;
        chk("bb1_rdata", MEM_ReadData, 32'h1234_5678);
        nxt();
        drive(1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0006, 32'h0000_BEEF);
        #1;
        chk("bb2_idle_req", {31'b0, dmem_req}, 32'h0);
        chk("bb2_idle_stall", {31'b0, mem_stall}, 32'h1);
        nxt();
        chk("bb2_req", {31'b0, dmem_req}, 32'h1);
        chk("bb2_be", {28'b0, dmem_be}, 32'hC);
        chk("bb2_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("bb2_addr", dmem_addr, 32'h0000_0004);
        chk("bb2_we", {31'b0, dmem_we}, 32'h1);
        dmem_ack = 1'b1;
        nxt();
        dmem_ack = 1'b0;
        #1;
        chk("bb2_rdata_kept", MEM_ReadData, 32'h1234_5678);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        // Asynchronous reset in the middle of REQ.
        nxt();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
        nxt();
        chk("ar_req_before", {31'b0, dmem_req}, 32'h1);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        chk("ar_req", {31'b0, dmem_req}, 32'h0);
        chk("ar_addr", dmem_addr, 32'h0);
        chk("ar_be", {28'b0, dmem_be}, 32'h0);
        chk("ar_rdata", MEM_ReadData, 32'h0);
        chk("ar_stall", {31'b0, mem_stall}, 32'h0);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("ar_rel_stall", {31'b0, mem_stall}, 32'h0);
        chk("ar_rel_req", {31'b0, dmem_req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller. It is the producer that feeds the MEM/WB pipeline register.
- Takes the access from EX/MEM and runs a req/ack handshake with data memory.
- Stalls the pipeline while the access is outstanding.
- Presents the captured raw read word as MEM_ReadData. Load-type extraction stays in WB.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ without dmem_ack before the access is aborted with bus_err. Must be ≥2.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_mem_valid  in  1  EX/MEM holds a live instruction.
- ex_mem_memread  in  1  instruction is a load.
- ex_mem_memwrite  in  1  instruction is a store.
- ex_mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- ex_mem_addr  in  32  byte address (ALU result).
- ex_mem_wdata  in  32  store data, right-aligned.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address: {ex_mem_addr[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completion, 1-cycle pulse.
- dmem_rdata  in  32  read word; valid only in the ack cycle.
- mem_stall  out  1  freeze IF/ID/EX/EX-MEM this cycle.
- MEM_ReadData  out  32  captured read word, to MEM/WB.
- align_err  out  1  1-cycle pulse: misaligned access, no request issued.
- bus_err  out  1  high for the DONE cycle of a timed-out access.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_ReadData, align_err, bus_err. Counter=0. Reset during REQ drops dmem_req immediately; no completion is reported.
- access = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite). If memread and memwrite are both set, treat the access as a store.
- misaligned = (size==01 & addr[0]) | (size∈{10,11} & addr[1:0]!=0).
- States: IDLE, REQ, DONE.
  - IDLE, access & !misaligned: mem_stall=1 (combinational). At the edge, register dmem_req=1 together with dmem_we/addr/be/wdata and go to REQ; counter=0.
  - IDLE, access & misaligned: mem_stall=0; align_err=1 for this cycle (combinational); stay in IDLE. The instruction advances.
  - IDLE, no access: mem_stall=0.
  - REQ: mem_stall=1; request signals held stable.
    - dmem_ack=1: capture MEM_ReadData<=dmem_rdata for a load (unchanged for a store); dmem_req<=0; go to DONE.
    - Otherwise counter++. When counter==TIMEOUT-1 with no ack: dmem_req<=0, MEM_ReadData<=0, bus_err<=1, go to DONE.
  - DONE: mem_stall=0 so the instruction advances into MEM/WB at this edge. bus_err clears at the exit edge. Always go to IDLE; the access is never relaunched from DONE.
- Latency with a zero-wait memory (ack in the first REQ cycle): 3 cycles per access, 2 of them stalled. Back-to-back accesses get a new IDLE decision in the cycle after DONE.
- Byte lanes:
  - byte: be=1<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata={2{wdata[15:0]}}.
  - word: be=1111; wdata=wdata.
  - Loads drive be per size too. dmem_we=0 for loads.
- dmem_ack is ignored in IDLE and DONE; a late ack after a timeout has no effect.
- MEM_ReadData holds its value between accesses.

Test Plan:
- Reset: assert rst_n=0 mid-REQ → dmem_req=0 asynchronously; all outputs 0. Release → IDLE, mem_stall=0.
- Word load addr 0x0000_0104, ack in the first REQ cycle with rdata 0xDEADBEEF → mem_stall high 2 cycles; dmem_addr=0x104, be=1111, we=0; MEM_ReadData=0xDEADBEEF in the DONE cycle with mem_stall=0.
- Byte store addr 0x0000_0203, wdata 0x0000_00A5, ack after 3 wait cycles → be=1000, dmem_wdata=0xA5A5A5A5, we=1, request stable until ack, mem_stall high 5 cycles.
- Half load addr 0x0000_0011 → align_err=1 for 1 cycle, dmem_req never asserted, mem_stall=0.
- Load, no ack, TIMEOUT=16 → dmem_req drops after 16 REQ cycles; DONE has bus_err=1 and MEM_ReadData=0. An ack 2 cycles later is ignored.
- Back-to-back: load then half store at 0x0000_0006 with immediate acks → second dmem_req rises 3 cycles after the first; be=1100, dmem_wdata={2{wdata[15:0]}}.
